tube_readout: RTL and testbench

- Readout controller and reader for a bank of NUM_TUBES per-tube hit timers. Each per-tube timer exposes an 8-bit clock-cycle hit time and takes clear, gate-enable, shift-freeze and validate controls.
- On a trigger, the block clears the tubes, opens a gate window, validates, and freezes the timers.
- It then snapshots all tube hit times and streams the hit tubes out, one word per hit, on a valid/ready interface toward the DAQ/serializer.

---
 rtl/tube_pkg.sv | 17 +
 rtl/tube_readout_if.sv | 22 ++
 rtl/tube_prio_enc.sv | 23 ++
 rtl/tube_readout.sv | 149 ++++++++++++++
 tb/tb_tube_readout.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared FSM states and constants for the tube readout block
package tube_pkg;
    localparam int TIME_W    = 8;
    localparam int MAX_TUBES = 32;
    localparam int ID_W      = 5;
    localparam logic [TIME_W-1:0] NO_HIT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_VALIDATE,
        S_SETTLE,
        S_SCAN,
        S_DONE
    } state_t;
endpackage

// File: rtl/tube_readout_if.sv
// rtl/tube_readout_if.sv - hit-word stream from the readout controller toward the DAQ
interface tube_readout_if;
    import tube_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [ID_W-1:0]   out_tube_id;
    logic [TIME_W-1:0] out_data;
    logic              out_empty;
    logic              out_last;
    logic [7:0]        out_event;

    modport master (
        output out_valid, out_tube_id, out_data, out_empty, out_last, out_event,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_tube_id, out_data, out_empty, out_last, out_event,
        output out_ready
    );
endinterface

// File: rtl/tube_prio_enc.sv
// rtl/tube_prio_enc.sv - lowest-set-bit encoder with any and single-bit flags
module tube_prio_enc
    import tube_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] idx,
    output logic            any,
    output logic            onehot
);
    localparam logic [N-1:0] ONE = N'(1);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end

    assign any    = |req;
    assign onehot = any && ((req & (req - ONE)) == '0);
endmodule

// File: rtl/tube_readout.sv
// rtl/tube_readout.sv - trigger-driven tube timer sequencing and hit-word readout
module tube_readout
    import tube_pkg::*;
#(
    parameter int NUM_TUBES   = 8,
    parameter int GATE_CYCLES = 200
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        trigger,
    input  logic [NUM_TUBES*TIME_W-1:0] tube_data,
    output logic                        tube_clr,
    output logic                        gate_enable,
    output logic                        shift_freeze,
    output logic                        validate_out,
    output logic                        busy,
    tube_readout_if.master              stream
);
    localparam int CNT_W = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES);

    state_t                      state;
    logic [CNT_W-1:0]            gate_cnt;
    logic [NUM_TUBES-1:0]        pending;
    logic [NUM_TUBES-1:0]        hit_mask;
    logic [NUM_TUBES-1:0]        taken_mask;
    logic [NUM_TUBES-1:0]        pend_nxt;
    logic [NUM_TUBES*TIME_W-1:0] snapshot;
    logic [MAX_TUBES*TIME_W-1:0] word_src;
    logic [TIME_W-1:0]           nxt_data;
    logic [ID_W-1:0]             nxt_id;
    logic                        nxt_any;
    logic                        nxt_onehot;
    logic                        handshake;

    assign handshake = stream.out_valid && stream.out_ready;

    always_comb begin
        hit_mask   = '0;
        taken_mask = '0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            hit_mask[i]   = tube_data[i*TIME_W +: TIME_W] != NO_HIT;
            taken_mask[i] = stream.out_tube_id == ID_W'(i);
        end
    end

    // The next word is encoded one cycle ahead so every stream output leaves a flop.
    assign pend_nxt = (state == S_SETTLE) ? hit_mask : (pending & ~taken_mask);

    always_comb begin
        word_src = '0;
        word_src[NUM_TUBES*TIME_W-1:0] = (state == S_SETTLE) ? tube_data : snapshot;
    end

    assign nxt_data = word_src[{nxt_id, 3'b000} +: TIME_W];

    tube_prio_enc #(.N(NUM_TUBES)) u_prio_enc (
        .req    (pend_nxt),
        .idx    (nxt_id),
        .any    (nxt_any),
        .onehot (nxt_onehot)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state              <= S_IDLE;
            gate_cnt           <= '0;
            pending            <= '0;
            snapshot           <= '0;
            tube_clr           <= 1'b0;
            gate_enable        <= 1'b0;
            shift_freeze       <= 1'b0;
            validate_out       <= 1'b0;
            busy               <= 1'b0;
            stream.out_valid   <= 1'b0;
            stream.out_tube_id <= '0;
            stream.out_data    <= '0;
            stream.out_empty   <= 1'b0;
            stream.out_last    <= 1'b0;
            stream.out_event   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state    <= S_CLEAR;
                        tube_clr <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state       <= S_GATE;
                    tube_clr    <= 1'b0;
                    gate_enable <= 1'b1;
                    gate_cnt    <= GATE_LOAD;
                end
                S_GATE: begin
                    if (gate_cnt == CNT_W'(1)) begin
                        state        <= S_VALIDATE;
                        gate_cnt     <= '0;
                        validate_out <= 1'b1;
                        shift_freeze <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt - 1'b1;
                    end
                end
                S_VALIDATE: begin
                    state        <= S_SETTLE;
                    gate_enable  <= 1'b0;
                    validate_out <= 1'b0;
                end
                S_SETTLE: begin
                    // An event with no hits still produces a single marker word.
                    state              <= S_SCAN;
                    snapshot           <= tube_data;
                    pending            <= pend_nxt;
                    stream.out_valid   <= 1'b1;
                    stream.out_tube_id <= nxt_id;
                    stream.out_data    <= nxt_any ? nxt_data : NO_HIT;
                    stream.out_empty   <= !nxt_any;
                    stream.out_last    <= nxt_onehot || !nxt_any;
                end
                S_SCAN: begin
                    if (handshake) begin
                        pending <= pend_nxt;
                        if (stream.out_last) begin
                            state              <= S_DONE;
                            stream.out_valid   <= 1'b0;
                            stream.out_tube_id <= '0;
                            stream.out_data    <= '0;
                            stream.out_empty   <= 1'b0;
                            stream.out_last    <= 1'b0;
                        end else begin
                            stream.out_tube_id <= nxt_id;
                            stream.out_data    <= nxt_data;
                            stream.out_last    <= nxt_onehot;
                        end
                    end
                end
                S_DONE: begin
                    state            <= S_IDLE;
                    stream.out_event <= stream.out_event + 8'd1;
                    shift_freeze     <= 1'b0;
                    busy             <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tube_readout.sv
// tb/tb_tube_readout.sv - randomized self-checking bench for tube_readout
module tb_tube_readout;
    localparam int N = 8;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         trigger = 1'b0;
    logic [N*8-1:0] tube_data = '1;
    logic         tube_clr, gate_enable, shift_freeze, validate_out, busy;
    int           total = 0;
    int           bad = 0;
    int           exp_event = 0;

    tube_readout_if ifc();

    tube_readout #(.NUM_TUBES(N), .GATE_CYCLES(G)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .trigger      (trigger),
        .tube_data    (tube_data),
        .tube_clr     (tube_clr),
        .gate_enable  (gate_enable),
        .shift_freeze (shift_freeze),
        .validate_out (validate_out),
        .busy         (busy),
        .stream       (ifc.master)
    );

    always #5 clk = ~clk;

    function automatic logic [N*8-1:0] rand_data();
        logic [N*8-1:0] d;
        d = '1;
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1) d[i*8 +: 8] = 8'($urandom_range(0, 254));
        return d;
    endfunction

    // mode 0: always ready, 1: random ready, 2: ready low 5 cycles after the first word
    task automatic run_event(input logic [N*8-1:0] data, input int mode, input bit poke);
        int          exp_id[$];
        logic [7:0]  exp_d[$];
        int          k, guard, stall, taken;
        bit          done, was_held, empty_ev;
        logic [4:0]  h_id;
        logic [7:0]  h_d;
        logic        h_e, h_l;
        tube_data = data;
        for (int i = 0; i < N; i++)
            if (data[i*8 +: 8] != 8'hFF) begin
                exp_id.push_back(i);
                exp_d.push_back(data[i*8 +: 8]);
            end
        empty_ev = (exp_id.size() == 0);
        if (empty_ev) begin
            exp_id.push_back(0);
            exp_d.push_back(8'hFF);
        end
        ifc.out_ready = 1'b0;
        @(negedge clk);
        trigger = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            trigger = poke && (k == 3);
        end while (!ifc.out_valid && k < 60);
        total++;
        if (k != G + 4) begin
            bad++;
            $display("FAIL latency got=%0d want=%0d", k, G + 4);
        end
        done = 0; guard = 0; stall = 0; taken = 0; was_held = 0;
        h_id = '0; h_d = '0; h_e = 1'b0; h_l = 1'b0;
        while (!done && guard < 300) begin
            if (guard > 0) @(negedge clk);
            guard++;
            trigger = poke && (guard == 1);
            total++;
            if (ifc.out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stream_valid got=%b want=1 word=%0d", ifc.out_valid, taken);
                done = 1;
            end
            if (was_held) begin
                total++;
                if ({ifc.out_tube_id, ifc.out_data, ifc.out_empty, ifc.out_last} !== {h_id, h_d, h_e, h_l}) begin
                    bad++;
                    $display("FAIL hold got=%h/%h/%b/%b want=%h/%h/%b/%b", ifc.out_tube_id, ifc.out_data,
                             ifc.out_empty, ifc.out_last, h_id, h_d, h_e, h_l);
                end
            end
            case (mode)
                0: ifc.out_ready = 1'b1;
                1: ifc.out_ready = ($urandom_range(0, 99) < 60);
                default: begin
                    if (taken == 1 && stall < 5) begin
                        ifc.out_ready = 1'b0;
                        stall++;
                    end else begin
                        ifc.out_ready = 1'b1;
                    end
                end
            endcase
            was_held = ifc.out_valid && !ifc.out_ready;
            h_id = ifc.out_tube_id; h_d = ifc.out_data; h_e = ifc.out_empty; h_l = ifc.out_last;
            if (!done && ifc.out_valid && ifc.out_ready) begin
                total++;
                if (taken >= exp_id.size()) begin
                    bad++;
                    $display("FAIL extra_word got_id=%0d want_words=%0d", ifc.out_tube_id, exp_id.size());
                    done = 1;
                end else begin
                    if (ifc.out_tube_id !== 5'(exp_id[taken])) begin
                        bad++;
                        $display("FAIL word_id got=%0d want=%0d", ifc.out_tube_id, exp_id[taken]);
                    end
                    total++;
                    if (ifc.out_data !== exp_d[taken]) begin
                        bad++;
                        $display("FAIL word_data got=%h want=%h", ifc.out_data, exp_d[taken]);
                    end
                    total++;
                    if (ifc.out_empty !== empty_ev) begin
                        bad++;
                        $display("FAIL word_empty got=%b want=%b", ifc.out_empty, empty_ev);
                    end
                    total++;
                    if (ifc.out_last !== (taken == exp_id.size() - 1)) begin
                        bad++;
                        $display("FAIL word_last got=%b want=%b", ifc.out_last, taken == exp_id.size() - 1);
                    end
                    total++;
                    if (ifc.out_event !== 8'(exp_event)) begin
                        bad++;
                        $display("FAIL word_event got=%0d want=%0d", ifc.out_event, exp_event);
                    end
                    taken++;
                    done = ifc.out_last;
                end
            end
        end
        total++;
        if (taken != exp_id.size()) begin
            bad++;
            $display("FAIL word_count got=%0d want=%0d", taken, exp_id.size());
        end
        @(negedge clk);
        ifc.out_ready = 1'b0;
        trigger = 1'b0;
        total++;
        if ({ifc.out_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL done_state got valid/busy=%b%b want=01", ifc.out_valid, busy);
        end
        @(negedge clk);
        exp_event = (exp_event + 1) % 256;
        total++;
        if ({busy, ifc.out_event} !== {1'b0, 8'(exp_event)}) begin
            bad++;
            $display("FAIL event_end got busy=%b ev=%0d want busy=0 ev=%0d", busy, ifc.out_event, exp_event);
        end
        if (poke) begin
            repeat (4) @(negedge clk);
            total++;
            if ({busy, ifc.out_valid} !== 2'b00) begin
                bad++;
                $display("FAIL queued_trigger got busy/valid=%b%b want=00", busy, ifc.out_valid);
            end
        end
    endtask

    task automatic test_reset();
        ifc.out_ready = 1'b0;
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({tube_clr, gate_enable, shift_freeze, validate_out, busy, ifc.out_valid, ifc.out_tube_id,
             ifc.out_data, ifc.out_empty, ifc.out_last, ifc.out_event} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got nonzero ev=%0d valid=%b busy=%b", ifc.out_event, ifc.out_valid, busy);
        end
        clr_n = 1'b1;
        exp_event = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timing();
        logic [5:0] want;
        tube_data = '1;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        trigger = 1'b1;
        for (int k = 1; k <= G + 4; k++) begin
            @(negedge clk);
            trigger = 1'b0;
            want = {k == 1, (k >= 2) && (k <= G + 2), k == G + 2, k >= G + 2, k == G + 4, 1'b1};
            total++;
            if ({tube_clr, gate_enable, validate_out, shift_freeze, ifc.out_valid, busy} !== want) begin
                bad++;
                $display("FAIL timeline cycle=%0d got=%b want=%b", k,
                         {tube_clr, gate_enable, validate_out, shift_freeze, ifc.out_valid, busy}, want);
            end
        end
        total++;
        if ({ifc.out_empty, ifc.out_data, ifc.out_last, ifc.out_tube_id} !== {1'b1, 8'hFF, 1'b1, 5'd0}) begin
            bad++;
            $display("FAIL empty_marker got e=%b d=%h l=%b id=%0d want e=1 d=ff l=1 id=0",
                     ifc.out_empty, ifc.out_data, ifc.out_last, ifc.out_tube_id);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        @(negedge clk);
        exp_event = (exp_event + 1) % 256;
        total++;
        if ({busy, shift_freeze, ifc.out_event} !== {2'b00, 8'(exp_event)}) begin
            bad++;
            $display("FAIL timing_end got busy=%b freeze=%b ev=%0d want 0 0 %0d", busy, shift_freeze,
                     ifc.out_event, exp_event);
        end
    endtask

    task automatic test_three_hits();
        logic [N*8-1:0] d;
        d = '1;
        d[15:8]  = 8'h20;
        d[31:24] = 8'h05;
        d[55:48] = 8'hF0;
        run_event(d, 0, 0);
    endtask

    task automatic test_no_hits();
        run_event('1, 0, 0);
    endtask

    task automatic test_backpressure();
        logic [N*8-1:0] d;
        d = '1;
        d[7:0]   = 8'h11;
        d[23:16] = 8'h42;
        d[39:32] = 8'h00;
        d[63:56] = 8'hFE;
        run_event(d, 2, 0);
        for (int i = 0; i < 6; i++) run_event(rand_data(), 1, 0);
    endtask

    task automatic test_ignored_trigger();
        run_event(rand_data(), 1, 1);
        run_event('1, 0, 1);
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        while (exp_event != 0 && n < 300) begin
            run_event(rand_data(), 0, 0);
            n++;
        end
        total++;
        if (ifc.out_event !== 8'd0) begin
            bad++;
            $display("FAIL wrap got=%0d want=0 after %0d events", ifc.out_event, n);
        end
    endtask

    task automatic test_abort();
        logic [N*8-1:0] d;
        int k;
        run_event(rand_data(), 0, 0);
        d = '0;
        for (int i = 0; i < N; i++) d[i*8 +: 8] = 8'($urandom_range(0, 254));
        tube_data = d;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        trigger = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            trigger = 1'b0;
            k++;
        end while (!ifc.out_valid && k < 60);
        @(negedge clk);
        total++;
        if (ifc.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup got valid=%b want=1", ifc.out_valid);
        end
        clr_n = 1'b0;
        @(negedge clk);
        total++;
        if ({tube_clr, gate_enable, shift_freeze, validate_out, busy, ifc.out_valid, ifc.out_tube_id,
             ifc.out_data, ifc.out_empty, ifc.out_last, ifc.out_event} !== '0) begin
            bad++;
            $display("FAIL abort_outputs got valid=%b busy=%b ev=%0d data=%h want all zero",
                     ifc.out_valid, busy, ifc.out_event, ifc.out_data);
        end
        clr_n = 1'b1;
        exp_event = 0;
        @(negedge clk);
        run_event(rand_data(), 1, 0);
    endtask

    initial begin
        ifc.out_ready = 1'b0;
        test_reset();
        test_timing();
        test_three_hits();
        test_no_hits();
        test_backpressure();
        test_ignored_trigger();
        test_wrap();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
